demux_1_8_dispatcher: RTL and testbench
=======================================

Name: demux_1_8_dispatcher

Overview:
- Sequencing controller that sits in front of the 1:8 demultiplexer.
- Accepts a valid/ready input word stream and grants the eight output channels in bursts of BURST_LEN words, round-robin over the enabled channels.
- Drives the demux Enable/Select lines and a registered data/valid pair per channel.
- Lives in Data_Selectors_and_Converters alongside the DEMUX blocks.

Parameters:
DATA_WIDTH, 8, width of the data word
BURST_LEN, 4, words sent to a channel before re-arbitration (legal range 1..255)

Ports:
Clk_In  input  1  clock, all logic on its rising edge
Reset_In  input  1  reset, synchronous, active-high
Data_In  input  DATA_WIDTH  input word
Data_Valid_In  input  1  Data_In is valid
Data_Ready_Out  output  1  dispatcher accepts Data_In this cycle
Channel_Enable_In  input  8  per-channel participation mask
Channel_Ready_In  input  8  per-channel sink ready
Enable_Out  output  1  demux enable, high only in XFER
Select_Out  output  3  demux select, index of the granted channel
Data_Out  output  DATA_WIDTH  registered word toward the demux
Channel_Valid_Out  output  8  one-hot, 1-cycle strobe for the word on Data_Out
Burst_Count_Out  output  8  words already sent in the current burst
Busy_Out  output  1  high in ARB or XFER

Behaviour:
- Clock and reset: one clock, Clk_In. Reset_In is synchronous and active-high.
- Reset values:
  - Outputs: Enable_Out=0, Select_Out=0, Data_Out=0, Channel_Valid_Out=0, Burst_Count_Out=0, Data_Ready_Out=0, Busy_Out=0.
  - Internal: state=IDLE, Last_Grant=7, so the first grant goes to channel 0.
  - Reset asserted mid-burst aborts the burst. No strobe is issued on the following cycle.
- States: IDLE, ARB, XFER.
- IDLE:
  - Enable_Out=0, Data_Ready_Out=0.
  - Next cycle -> ARB if Channel_Enable_In!=0, else stay in IDLE.
- ARB (exactly one cycle):
  - Search channels Last_Grant+1, Last_Grant+2, ... with mod-8 wrap.
  - First channel with Channel_Enable_In set is latched into Select_Out; Burst_Count_Out<=0; go to XFER.
  - No enabled channel -> IDLE, Select_Out unchanged.
  - Data_Ready_Out=0 in ARB.
- XFER:
  - Enable_Out=1, Select_Out held.
  - Data_Ready_Out = Channel_Ready_In[Select_Out] & Channel_Enable_In[Select_Out] (combinational).
  - Transfer occurs when Data_Valid_In & Data_Ready_Out. On a transfer:
    - Data_Out<=Data_In.
    - Channel_Valid_Out<=one-hot(Select_Out) for exactly one cycle (1-cycle latency).
    - Burst_Count_Out increments.
  - No transfer -> Channel_Valid_Out<=0 and Data_Out holds its value.
  - Sink contract: a channel asserting Channel_Ready_In in the transfer cycle must take the strobe on the next cycle. No back-pressure exists on the registered stage.
- XFER exits:
  - Transfer with Burst_Count_Out==BURST_LEN-1 -> Last_Grant<=Select_Out, Burst_Count_Out<=0, go to ARB.
  - Channel_Enable_In[Select_Out]==0 -> end the burst early: Last_Grant<=Select_Out, go to ARB. No transfer is possible that cycle because ready is gated by enable.
  - Input stall (Data_Valid_In=0) or sink stall -> stay in XFER indefinitely. There is no timeout.
- Mask changes:
  - Changes to channels other than the granted one take effect at the next ARB only.
  - A mask of 0 seen in ARB -> IDLE; the next grant resumes from Last_Grant+1.
- Arithmetic:
  - Burst_Count_Out is 8-bit unsigned and never exceeds BURST_LEN-1.
  - The round-robin index wraps 7->0.
- Outputs: all outputs except Data_Ready_Out are registered. Busy_Out=(state!=IDLE).

Test Plan:
1. Reset, then Channel_Enable_In=8'hFF, Data_Valid_In=1 held, all ready, Data_In incrementing from 8'h00 -> channel 0 gets 00..03, channel 1 gets 04..07, ..., channel 7 gets 1C..1F, then channel 0 again. Each burst is preceded by one ARB cycle with Data_Ready_Out=0.
2. Channel_Enable_In=8'b1000_0100, continuous valid data -> grants alternate 2,7,2,7. Select_Out shows only 2 or 7. Channel_Valid_Out is only 8'h04 or 8'h80.
3. Granted channel 3 drops Channel_Ready_In for 5 cycles after its 2nd word -> Data_Ready_Out=0 for those 5 cycles and no strobe. The burst resumes on channel 3 with Burst_Count_Out=2 and completes 4 words total.
4. Channel_Enable_In[5] cleared during a channel-5 burst at Burst_Count_Out=1 -> ARB on the next cycle, next grant is channel 6 (if enabled), channel 5 receives no further strobes.
5. Channel_Enable_In=0 while in IDLE -> state stays IDLE, Enable_Out=0, Busy_Out=0. Then set 8'h10 -> ARB, then XFER with Select_Out=4.
6. Reset_In asserted during XFER -> the next cycle shows all outputs at reset values. The next grant after release is channel 0.

Source files
------------

// File: rtl/demux_1_8_dispatcher.sv
// Sequencing controller in front of the 1:8 demux: grants enabled channels
// round-robin in bursts of BURST_LEN words and registers each accepted word.
module demux_1_8_dispatcher #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  input  logic [7:0]            Channel_Enable_In,
  input  logic [7:0]            Channel_Ready_In,
  output logic                  Enable_Out,
  output logic [2:0]            Select_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic [7:0]            Channel_Valid_Out,
  output logic [7:0]            Burst_Count_Out,
  output logic                  Busy_Out
);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(BURST_LEN - 1);

  state_t     state;
  logic [2:0] last_grant;
  logic [2:0] next_grant;
  logic [2:0] probe;
  logic       grant_found;
  logic       fire;

  assign Data_Ready_Out = (state == XFER) & Channel_Ready_In[Select_Out]
                        & Channel_Enable_In[Select_Out];
  assign fire = Data_Valid_In & Data_Ready_Out;

  // Scan from the farthest offset down so the nearest enabled channel after
  // last_grant wins; offset 8 wraps back onto last_grant itself.
  always_comb begin
    next_grant  = last_grant;
    grant_found = 1'b0;
    probe       = '0;
    for (int unsigned i = 8; i >= 1; i--) begin
      probe = last_grant + 3'(i);
      if (Channel_Enable_In[probe]) begin
        next_grant  = probe;
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state             <= IDLE;
      last_grant        <= 3'd7;
      Enable_Out        <= 1'b0;
      Select_Out        <= '0;
      Data_Out          <= '0;
      Channel_Valid_Out <= '0;
      Burst_Count_Out   <= '0;
      Busy_Out          <= 1'b0;
    end else begin
      Channel_Valid_Out <= '0;
      case (state)
        IDLE: begin
          Enable_Out <= 1'b0;
          if (|Channel_Enable_In) begin
            state    <= ARB;
            Busy_Out <= 1'b1;
          end else begin
            Busy_Out <= 1'b0;
          end
        end
        ARB: begin
          if (grant_found) begin
            state           <= XFER;
            Select_Out      <= next_grant;
            Burst_Count_Out <= '0;
            Enable_Out      <= 1'b1;
            Busy_Out        <= 1'b1;
          end else begin
            state      <= IDLE;
            Enable_Out <= 1'b0;
            Busy_Out   <= 1'b0;
          end
        end
        XFER: begin
          if (!Channel_Enable_In[Select_Out]) begin
            last_grant <= Select_Out;
            state      <= ARB;
            Enable_Out <= 1'b0;
          end else if (fire) begin
            Data_Out          <= Data_In;
            Channel_Valid_Out <= 8'(1) << Select_Out;
            if (Burst_Count_Out == LAST_COUNT) begin
              Burst_Count_Out <= '0;
              last_grant      <= Select_Out;
              state           <= ARB;
              Enable_Out      <= 1'b0;
            end else begin
              Burst_Count_Out <= Burst_Count_Out + 8'd1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          Enable_Out <= 1'b0;
          Busy_Out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1_8_dispatcher.sv
// Bench for demux_1_8_dispatcher: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the dispatch rules.
module tb_demux_1_8_dispatcher;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          vld;
  logic          rdy_out;
  logic [7:0]    msk;
  logic [7:0]    crdy;
  logic          en_out;
  logic [2:0]    sel_out;
  logic [DW-1:0] dout;
  logic [7:0]    cv_out;
  logic [7:0]    cnt_out;
  logic          busy_out;

  demux_1_8_dispatcher #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .Clk_In(clk), .Reset_In(rst), .Data_In(din), .Data_Valid_In(vld),
    .Data_Ready_Out(rdy_out), .Channel_Enable_In(msk), .Channel_Ready_In(crdy),
    .Enable_Out(en_out), .Select_Out(sel_out), .Data_Out(dout),
    .Channel_Valid_Out(cv_out), .Burst_Count_Out(cnt_out), .Busy_Out(busy_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 arbitrating, 2 streaming a burst.
  int         m_phase, m_sel, m_last, m_cnt;
  logic [7:0] m_data, m_cv;
  logic       m_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_last = 7; m_cnt = 0; m_data = '0; m_cv = '0;
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic v,
                      input logic [7:0] mk, input logic [7:0] cr);
    logic exp_rdy;
    bit   found;
    rst = r; din = d; vld = v; msk = mk; crdy = cr;
    #1;
    exp_rdy = (m_phase == 2) && cr[m_sel] && mk[m_sel];
    check("ready", 32'(rdy_out), 32'(exp_rdy));
    m_fire = 1'b0;
    m_cv   = '0;
    if (r) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (mk != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      found = 0;
      for (int k = 1; k <= 8; k++)
        if (!found && mk[(m_last + k) % 8]) begin
          found = 1; m_sel = (m_last + k) % 8;
        end
      if (found) begin m_phase = 2; m_cnt = 0; end
      else m_phase = 0;
    end else begin
      if (!mk[m_sel]) begin
        m_last = m_sel; m_phase = 1;
      end else if (v && cr[m_sel]) begin
        m_fire = 1'b1;
        m_data = d;
        m_cv   = 8'(1 << m_sel);
        m_cnt++;
        if (m_cnt == BL) begin
          m_cnt = 0; m_last = m_sel; m_phase = 1;
        end
      end
    end
    @(posedge clk); #1;
    check("enable", 32'(en_out), 32'(m_phase == 2));
    check("busy", 32'(busy_out), 32'(m_phase != 0));
    check("select", 32'(sel_out), 32'(m_sel));
    check("data", 32'(dout), 32'(m_data));
    check("strobe", 32'(cv_out), 32'(m_cv));
    check("count", 32'(cnt_out), 32'(m_cnt));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] rm;
    int         k;
    bit         hit;

    rst = 1'b1; din = '0; vld = 1'b0; msk = '0; crdy = '0;
    model_reset();

    // Reset, then all channels with continuous data: 4-word bursts 0..7.
    step(1, 8'h00, 0, 8'h00, 8'h00);
    step(1, 8'h00, 0, 8'h00, 8'h00);
    d = 8'h00; k = 0;
    for (int c = 0; c < 50; c++) begin
      step(0, d, 1, 8'hFF, 8'hFF);
      if (m_fire) d++;
      if (cv_out != 0) begin
        check("p1_chan", 32'(cv_out), 32'(1 << ((k / 4) % 8)));
        check("p1_word", 32'(dout), 32'(k));
        k++;
      end
    end

    // Two enabled channels alternate.
    for (int c = 0; c < 40; c++) begin
      step(0, 8'($urandom), 1, 8'b1000_0100, 8'hFF);
      check("p2_strobe_set", 32'(cv_out == 0 || cv_out == 8'h04 || cv_out == 8'h80), 1);
    end

    // Sink stall on channel 3 after its second word.
    step(1, 8'h00, 0, 8'h00, 8'h00);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      step(0, 8'($urandom), 1, 8'h08, 8'hFF);
      hit = (en_out && sel_out == 3'd3 && cnt_out == 8'd2);
    end
    check("p3_reach", 32'(hit), 1);
    for (int c = 0; c < 5; c++) begin
      step(0, 8'($urandom), 1, 8'h08, 8'hF7);
      check("p3_stall_ready", 32'(rdy_out), 0);
    end
    check("p3_hold_count", 32'(cnt_out), 2);
    for (int c = 0; c < 4; c++) step(0, 8'($urandom), 1, 8'h08, 8'hFF);

    // Granted channel 5 disabled mid-burst.
    step(1, 8'h00, 0, 8'h00, 8'h00);
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      step(0, 8'($urandom), 1, 8'hFF, 8'hFF);
      hit = (en_out && sel_out == 3'd5 && cnt_out == 8'd1);
    end
    check("p4_reach", 32'(hit), 1);
    step(0, 8'($urandom), 1, 8'hDF, 8'hFF);
    step(0, 8'($urandom), 1, 8'hDF, 8'hFF);
    check("p4_next_grant", 32'(sel_out), 6);
    for (int c = 0; c < 40; c++) begin
      step(0, 8'($urandom), 1, 8'hDF, 8'hFF);
      check("p4_no_ch5", 32'(cv_out[5]), 0);
    end

    // Empty mask idles; enabling channel 4 grants it.
    step(1, 8'h00, 0, 8'h00, 8'h00);
    for (int c = 0; c < 5; c++) step(0, 8'h00, 1, 8'h00, 8'hFF);
    check("p5_idle_busy", 32'(busy_out), 0);
    step(0, 8'h00, 1, 8'h10, 8'hFF);
    check("p5_arb_busy", 32'(busy_out), 1);
    step(0, 8'h00, 1, 8'h10, 8'hFF);
    check("p5_grant", 32'(sel_out), 4);

    // Reset mid-burst aborts it; first grant afterwards is channel 0.
    step(1, 8'h00, 0, 8'h00, 8'h00);
    for (int c = 0; c < 12; c++) step(0, 8'($urandom), 1, 8'hF0, 8'hFF);
    check("p6_in_xfer", 32'(en_out), 1);
    step(1, 8'($urandom), 1, 8'hF0, 8'hFF);
    check("p6_reset_strobe", 32'(cv_out), 0);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      step(0, 8'($urandom), 1, 8'hFF, 8'hFF);
      hit = (cv_out != 0);
    end
    check("p6_first_after_reset", 32'(cv_out), 32'h01);

    // Random traffic with mask churn, stalls and occasional reset.
    rm = 8'hFF;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0)
        rm = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 199) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
           rm, 8'($urandom | $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
